// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: one-hot FSM states,
// parity mode codes and the 2-of-3 vote helper.
// Optional majority sampling is selected with UART_RX_MAJORITY_EN (see sampler).
package uart_pkg;

  // One-hot state codes; each state owns exactly one flop of the state register.
  localparam logic [6:0] IDLE   = 7'b0000001;
  localparam logic [6:0] START  = 7'b0000010;
  localparam logic [6:0] DATA   = 7'b0000100;
  localparam logic [6:0] PARITY = 7'b0001000;
  localparam logic [6:0] STOP   = 7'b0010000;
  localparam logic [6:0] DONE   = 7'b0100000;
  localparam logic [6:0] BREAK  = 7'b1000000;

  typedef enum logic [6:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP,
    S_DONE   = DONE,
    S_BREAK  = BREAK
  } state_t;

  // Parity modes.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // 2-of-3 majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning: 2-FF synchroniser, plus a tick-qualified 3-sample vote
// when UART_RX_MAJORITY_EN is defined (otherwise the vote is the plain sample).
// Latency: 2 clocks line-to-rx_s; vote is combinational on rx_s. No backpressure.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_rx_vote
);

  logic sync1_q;
  logic sync2_q;

  // Two-stage synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  assign o_rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // The window is the two previous tick samples plus the live sample, so the
  // vote is ready on the sampling tick itself and latency matches the plain build.
  logic [1:0] hist_q;

  // Capture rx_s on every tick to form the 3-sample window.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hist_q <= 2'b11;
    end else if (i_tick) begin
      hist_q <= {hist_q[0], sync2_q};
    end
  end

  assign o_rx_vote = maj3(hist_q[1], hist_q[0], sync2_q);
`else
  logic unused_tick;
  assign unused_tick = i_tick;
  assign o_rx_vote   = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (DATA_BITS, OVERSAMPLE, PARITY_MODE, STOP_BITS);
// build with UART_RX_MAJORITY_EN for 2-of-3 bit voting.
// Latency: o_done_bit registered on the last stop-bit sampling edge. No backpressure.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx_data_input,
  output logic [DATA_BITS-1:0] o_data_byte,
  output logic                 o_done_bit,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int              CNT_W     = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

  logic rx_s;
  logic rx_vote;

  uart_rx_sampler u_sampler (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_tick    (i_tick),
    .i_rx      (i_rx_data_input),
    .o_rx_s    (rx_s),
    .o_rx_vote (rx_vote)
  );

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 ferr_acc_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 perr_q;
  logic                 ferr_q;

  // XOR of received data and parity bit: 0 for even total ones, 1 for odd.
  logic par_xor;
  logic par_err;
  assign par_xor = (^shift_q) ^ par_q;
  assign par_err = (PARITY_MODE == PAR_EVEN) ? par_xor :
                   (PARITY_MODE == PAR_ODD)  ? ~par_xor : 1'b0;

  // Frame FSM with registered outputs; the counter clears on every state entry.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q      <= '0;
          idx_q      <= '0;
          ferr_acc_q <= 1'b0;
          if (!rx_s) state_q <= S_START;
        end
        S_START: begin
          if (i_tick) begin
            if (cnt_q == HALF_M1) begin
              cnt_q   <= '0;
              // A high mid-start sample means the falling edge was a glitch.
              state_q <= rx_vote ? S_IDLE : S_DATA;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (i_tick) begin
            if (cnt_q == FULL_M1) begin
              cnt_q   <= '0;
              // LSB arrives first, so shifting in from the top leaves it at bit 0.
              shift_q <= {rx_vote, shift_q[DATA_BITS-1:1]};
              if (idx_q == LAST_DATA) begin
                idx_q   <= '0;
                state_q <= (PARITY_MODE != PAR_NONE) ? S_PARITY : S_STOP;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (i_tick) begin
            if (cnt_q == FULL_M1) begin
              cnt_q   <= '0;
              par_q   <= rx_vote;
              state_q <= S_STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (i_tick) begin
            if (cnt_q == FULL_M1) begin
              cnt_q <= '0;
              if (!rx_vote) ferr_acc_q <= 1'b1;
              if (idx_q == LAST_STOP) begin
                idx_q   <= '0;
                state_q <= S_DONE;
                // Outputs load on the DONE-entry edge so they are stable with done.
                done_q  <= 1'b1;
                data_q  <= shift_q;
                perr_q  <= par_err;
                ferr_q  <= ferr_acc_q | ~rx_vote;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          // A line still low here is a break, not a new start bit.
          state_q <= rx_s ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          cnt_q <= '0;
          if (rx_s) state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_data_byte  = data_q;
  assign o_done_bit   = done_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1/16x, 7E2/8x, 9O1/32x) driven
// bit-by-bit on their own lines, with frames checked against an arithmetic model.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;
  int   tick_div = 1;
  int   tcnt = 0;
  longint cyc = 0;

  int checks = 0;
  int passes = 0;

  logic [7:0] d0;
  logic [6:0] d1;
  logic [8:0] d2;
  logic done0, pe0, fe0, busy0;
  logic done1, pe1, fe1, busy1;
  logic done2, pe2, fe2, busy2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
    tick = (tcnt == 0);
  end

  uart_rx_param dut0 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx_data_input(rx0),
    .o_data_byte(d0), .o_done_bit(done0), .o_parity_err(pe0),
    .o_frame_err(fe0), .o_busy(busy0)
  );

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_MODE(2), .STOP_BITS(2)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx_data_input(rx1),
    .o_data_byte(d1), .o_done_bit(done1), .o_parity_err(pe1),
    .o_frame_err(fe1), .o_busy(busy1)
  );

  uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(32), .PARITY_MODE(1), .STOP_BITS(1)) dut2 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx_data_input(rx2),
    .o_data_byte(d2), .o_done_bit(done2), .o_parity_err(pe2),
    .o_frame_err(fe2), .o_busy(busy2)
  );

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    longint     cyc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  // Record every completed frame of each receiver.
  always @(negedge clk) begin
    if (done0 === 1'b1) q0.push_back('{{1'b0, d0}, pe0, fe0, cyc});
    if (done1 === 1'b1) q1.push_back('{{2'b00, d1}, pe1, fe1, cyc});
    if (done2 === 1'b1) q2.push_back('{d2, pe2, fe2, cyc});
  end

  // ---------------- reference model ----------------
  function automatic int cfg_bits(input int idx);
    return (idx == 0) ? 8 : (idx == 1) ? 7 : 9;
  endfunction
  function automatic int cfg_os(input int idx);
    return (idx == 0) ? 16 : (idx == 1) ? 8 : 32;
  endfunction
  function automatic int cfg_pm(input int idx);
    return (idx == 0) ? 0 : (idx == 1) ? 2 : 1;
  endfunction
  function automatic int cfg_ns(input int idx);
    return (idx == 1) ? 2 : 1;
  endfunction

  // Parity error from the total count of ones over data and parity bit.
  function automatic logic exp_perr(input int pm, input logic [8:0] d, input logic pb);
    int ones;
    ones = $countones(d) + int'(pb);
    if (pm == 2) return (ones % 2) != 0;
    if (pm == 1) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic good_parity(input int pm, input logic [8:0] d);
    return (pm == 2) ? (($countones(d) % 2) != 0) : (($countones(d) % 2) == 0);
  endfunction

  function automatic logic exp_ferr(input int ns, input logic [1:0] stops);
    return (stops[0] == 1'b0) || (ns == 2 && stops[1] == 1'b0);
  endfunction

  function automatic int qsize(input int idx);
    if (idx == 0) return q0.size();
    if (idx == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic ev_t qpop(input int idx);
    if (idx == 0) return q0.pop_front();
    if (idx == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  // ---------------- line driving ----------------
  task automatic set_line(input int idx, input logic v);
    if (idx == 0) rx0 = v;
    else if (idx == 1) rx1 = v;
    else rx2 = v;
  endtask

  // Wait for n tick-qualified rising edges, then return on the next falling edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int idx, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input bit spike, input int abort_bit);
    int os;
    os = cfg_os(idx);
    set_line(idx, 1'b0);
    wait_ticks(os);
    for (int i = 0; i < cfg_bits(idx); i++) begin
      set_line(idx, data[i]);
      if (i == abort_bit) begin
        wait_ticks(os / 2);
        return;
      end
      if (spike) begin
        wait_ticks(os / 2);
        set_line(idx, ~data[i]);
        wait_ticks(1);
        set_line(idx, data[i]);
        wait_ticks(os - os / 2 - 1);
      end else begin
        wait_ticks(os);
      end
    end
    if (cfg_pm(idx) != 0) begin
      set_line(idx, pbit);
      wait_ticks(os);
    end
    for (int j = 0; j < cfg_ns(idx); j++) begin
      set_line(idx, stops[j]);
      wait_ticks(os);
    end
  endtask

  task automatic wait_frame(input int idx);
    for (int t = 0; t < 400 && qsize(idx) == 0; t++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if ({d0, done0, pe0, fe0, busy0} !== 12'h0)
      $display("FAIL reset_dut0: outputs %0h required 0", {d0, done0, pe0, fe0, busy0});
    else passes++;
    checks++; if ({d1, done1, pe1, fe1, busy1, d2, done2, pe2, fe2, busy2} !== 24'h0)
      $display("FAIL reset_dut12: outputs %0h required 0", {d1, done1, pe1, fe1, busy1, d2, done2, pe2, fe2, busy2});
    else passes++;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if ({busy0, busy1, busy2} !== 3'b000 || q0.size() + q1.size() + q2.size() != 0)
      $display("FAIL idle_after_reset: busy %b frames %0d required 000/0", {busy0, busy1, busy2}, q0.size() + q1.size() + q2.size());
    else passes++;
  endtask

  task automatic test_basic_8n1();
    ev_t e;
    longint c0;
    longint exp_lat;
    exp_lat = longint'((1 + 8 + 1) * 16 - 16 / 2 + 4);
    c0 = cyc;
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0, -1);
    wait_frame(0);
    repeat (20) @(negedge clk);
    checks++; if (q0.size() != 1) $display("FAIL basic_count: frames %0d required 1", q0.size());
    else passes++;
    if (q0.size() > 0) begin
      e = qpop(0);
      checks++; if (e.data !== 9'h0A5) $display("FAIL basic_data: got %0h required a5", e.data);
      else passes++;
      checks++; if ({e.perr, e.ferr} !== 2'b00) $display("FAIL basic_flags: got %b required 00", {e.perr, e.ferr});
      else passes++;
      checks++; if (e.cyc - c0 < exp_lat - 1 || e.cyc - c0 > exp_lat + 1)
        $display("FAIL basic_latency: got %0d clocks required %0d +/-1", e.cyc - c0, exp_lat);
      else passes++;
    end
    q0.delete();
  endtask

  task automatic test_parity_even();
    ev_t e;
    for (int k = 0; k < 2; k++) begin
      send_frame(1, 9'h041, logic'(k), 2'b11, 1'b0, -1);
      wait_frame(1);
      checks++; if (q1.size() != 1) $display("FAIL parity_count%0d: frames %0d required 1", k, q1.size());
      else passes++;
      if (q1.size() > 0) begin
        e = qpop(1);
        checks++; if (e.data !== 9'h041) $display("FAIL parity_data%0d: got %0h required 41", k, e.data);
        else passes++;
        checks++; if (e.perr !== exp_perr(2, 9'h041, logic'(k)) || e.ferr !== 1'b0)
          $display("FAIL parity_flag%0d: perr/ferr %b%b required %b0", k, e.perr, e.ferr, exp_perr(2, 9'h041, logic'(k)));
        else passes++;
      end
      q1.delete();
      wait_ticks(16);
    end
  endtask

  task automatic test_stop_break();
    ev_t e;
    bit busy_ok;
    send_frame(1, 9'h03C, good_parity(2, 9'h03C), 2'b01, 1'b0, -1);
    wait_frame(1);
    checks++; if (q1.size() != 1) $display("FAIL stop_count: frames %0d required 1", q1.size());
    else passes++;
    if (q1.size() > 0) begin
      e = qpop(1);
      checks++; if (e.data !== 9'h03C) $display("FAIL stop_data: got %0h required 3c", e.data);
      else passes++;
      checks++; if ({e.perr, e.ferr} !== 2'b01) $display("FAIL stop_flags: perr/ferr %b required 01", {e.perr, e.ferr});
      else passes++;
    end
    busy_ok = 1'b1;
    for (int b = 0; b < 40; b++) begin
      wait_ticks(8);
      if (busy1 !== 1'b1) busy_ok = 1'b0;
    end
    checks++; if (!busy_ok || q1.size() != 0)
      $display("FAIL break_hold: busy_held %0d frames %0d required 1/0", busy_ok, q1.size());
    else passes++;
    set_line(1, 1'b1);
    for (int t = 0; t < 20 && busy1 !== 1'b0; t++) @(negedge clk);
    checks++; if (busy1 !== 1'b0) $display("FAIL break_release: busy %b required 0", busy1);
    else passes++;
    wait_ticks(16);
  endtask

  task automatic test_glitch();
    ev_t e;
    set_line(0, 1'b0);
    wait_ticks(4);
    checks++; if (busy0 !== 1'b1) $display("FAIL glitch_busy: busy %b required 1", busy0);
    else passes++;
    set_line(0, 1'b1);
    wait_ticks(40);
    checks++; if (busy0 !== 1'b0 || q0.size() != 0)
      $display("FAIL glitch_reject: busy %b frames %0d required 0/0", busy0, q0.size());
    else passes++;
    send_frame(0, 9'h055, 1'b0, 2'b11, 1'b0, -1);
    wait_frame(0);
    if (q0.size() == 0) begin
      checks++; $display("FAIL glitch_follow: no frame required 1");
    end else begin
      e = qpop(0);
      checks++; if (e.data !== 9'h055 || {e.perr, e.ferr} !== 2'b00)
        $display("FAIL glitch_follow: data %0h flags %b required 55/00", e.data, {e.perr, e.ferr});
      else passes++;
    end
    q0.delete();
  endtask

  task automatic test_reset_midframe();
    ev_t e;
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 1'b0, 3);
    checks++; if (busy0 !== 1'b1) $display("FAIL midframe_busy: busy %b required 1", busy0);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({d0, done0, pe0, fe0, busy0} !== 12'h0)
      $display("FAIL midframe_reset: outputs %0h required 0", {d0, done0, pe0, fe0, busy0});
    else passes++;
    rst = 1'b0;
    set_line(0, 1'b1);
    wait_ticks(200);
    checks++; if (q0.size() != 0) $display("FAIL midframe_nodone: frames %0d required 0", q0.size());
    else passes++;
    send_frame(0, 9'h012, 1'b0, 2'b11, 1'b0, -1);
    wait_frame(0);
    if (q0.size() == 0) begin
      checks++; $display("FAIL midframe_follow: no frame required 1");
    end else begin
      e = qpop(0);
      checks++; if (e.data !== 9'h012 || {e.perr, e.ferr} !== 2'b00)
        $display("FAIL midframe_follow: data %0h flags %b required 12/00", e.data, {e.perr, e.ferr});
      else passes++;
    end
    q0.delete();
  endtask

  task automatic test_spike();
    ev_t e;
    logic [8:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 9'h096;
`else
    exp_d = 9'h069;
`endif
    send_frame(0, 9'h096, 1'b0, 2'b11, 1'b1, -1);
    wait_frame(0);
    if (q0.size() == 0) begin
      checks++; $display("FAIL spike: no frame required 1");
    end else begin
      e = qpop(0);
      checks++; if (e.data !== exp_d) $display("FAIL spike_data: got %0h required %0h", e.data, exp_d);
      else passes++;
    end
    q0.delete();
    wait_ticks(16);
  endtask

  task automatic test_random();
    ev_t e;
    int idx;
    logic [8:0] data;
    logic [8:0] mask;
    logic pbit;
    logic [1:0] stops;
    for (int n = 0; n < 12; n++) begin
      idx = int'($urandom_range(0, 2));
      tick_div = int'($urandom_range(1, 3));
      wait_ticks(4);
      mask = 9'((1 << cfg_bits(idx)) - 1);
      data = 9'($urandom) & mask;
      pbit = good_parity(cfg_pm(idx), data) ^ ($urandom_range(0, 3) == 0);
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send_frame(idx, data, pbit, stops, 1'b0, -1);
      set_line(idx, 1'b1);
      wait_frame(idx);
      if (qsize(idx) == 0) begin
        checks++; $display("FAIL rand%0d_timeout: no frame on dut%0d", n, idx);
      end else begin
        e = qpop(idx);
        checks++; if (e.data !== data) $display("FAIL rand%0d_data: dut%0d got %0h required %0h", n, idx, e.data, data);
        else passes++;
        checks++; if (e.perr !== exp_perr(cfg_pm(idx), data, pbit))
          $display("FAIL rand%0d_perr: dut%0d got %b required %b", n, idx, e.perr, exp_perr(cfg_pm(idx), data, pbit));
        else passes++;
        checks++; if (e.ferr !== exp_ferr(cfg_ns(idx), stops))
          $display("FAIL rand%0d_ferr: dut%0d got %b required %b", n, idx, e.ferr, exp_ferr(cfg_ns(idx), stops));
        else passes++;
      end
      wait_ticks(3 * cfg_os(idx));
    end
    tick_div = 1;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    test_reset();
    test_basic_8n1();
    test_parity_even();
    test_stop_break();
    test_glitch();
    test_reset_midframe();
    test_spike();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
